// File: rtl/soma_lif_integrator_if.sv
// rtl/soma_lif_integrator_if.sv - weight/step input and spike output bundle for the LIF soma
interface soma_lif_integrator_if;
    logic [15:0] weight_in;
    logic        weight_valid;
    logic        step;
    logic        spike_out;
    logic [6:0]  spike_id;

    modport master (output weight_in, weight_valid, step, input spike_out, spike_id);
    modport slave  (input weight_in, weight_valid, step, output spike_out, spike_id);
endinterface

// File: rtl/soma_lif_integrator.sv
// rtl/soma_lif_integrator.sv - leaky integrate-and-fire soma with saturating membrane and refractory period
module soma_lif_integrator #(
    parameter logic [6:0]                NEURON_ID  = 7'd0,
    parameter int                        V_WIDTH    = 20,
    parameter logic signed [V_WIDTH-1:0] V_TH       = 20'sh00A00,
    parameter logic signed [V_WIDTH-1:0] V_RESET    = 20'sh00000,
    parameter int                        LEAK_SHIFT = 4,
    parameter int                        REFRAC     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                kill,
    soma_lif_integrator_if.slave s_if,
    output logic [V_WIDTH-1:0]  v_mem,
    output logic                refractory,
    output logic                busy,
    output logic                step_ovf
);
    localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
    localparam int EW = V_WIDTH + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_LEAK, ST_CHECK, ST_FIRE} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic signed [V_WIDTH-1:0]  r_v;
    logic signed [V_WIDTH-1:0]  r_pend;
    logic [RW-1:0]              r_ref_cnt;
    logic                       r_step_pend;
    logic                       r_step_ovf;

    logic signed [EW-1:0]       w_v_ext;
    logic signed [EW-1:0]       w_pend_ext;
    logic signed [EW-1:0]       w_w_ext;
    logic signed [EW-1:0]       w_w_term;
    logic signed [V_WIDTH-1:0]  w_leak;
    logic                       w_fire;

    // Sums are formed two bits wider so a single clamp covers v + pend + w.
    function automatic logic signed [V_WIDTH-1:0] sat(input logic signed [EW-1:0] x);
        if (x[EW-1:V_WIDTH-1] == 3'b000 || x[EW-1:V_WIDTH-1] == 3'b111)
            sat = x[V_WIDTH-1:0];
        else if (x[EW-1])
            sat = {1'b1, {(V_WIDTH-1){1'b0}}};
        else
            sat = {1'b0, {(V_WIDTH-1){1'b1}}};
    endfunction

    assign w_v_ext    = {{2{r_v[V_WIDTH-1]}}, r_v};
    assign w_pend_ext = {{2{r_pend[V_WIDTH-1]}}, r_pend};
    assign w_w_ext    = {{(EW-16){s_if.weight_in[15]}}, s_if.weight_in};
    assign w_w_term   = s_if.weight_valid ? w_w_ext : '0;
    assign w_leak     = r_v - (r_v >>> LEAK_SHIFT);
    assign w_fire     = (r_v >= V_TH);

    always_ff @(posedge clk) begin
        if (!rst || kill)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (s_if.step || r_step_pend) w_state_nxt = ST_LEAK;
            ST_LEAK:  w_state_nxt = ST_CHECK;
            ST_CHECK: w_state_nxt = w_fire ? ST_FIRE : ST_IDLE;
            ST_FIRE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || kill) begin
            r_v         <= '0;
            r_pend      <= '0;
            r_ref_cnt   <= '0;
            r_step_pend <= 1'b0;
            r_step_ovf  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // pend is zero except on the first idle cycle after a busy stretch
                    if (r_ref_cnt == '0)
                        r_v <= sat(w_v_ext + w_pend_ext + w_w_term);
                    r_pend      <= '0;
                    r_step_pend <= r_step_pend & s_if.step;
                end
                ST_LEAK: begin
                    r_v <= w_leak;
                    if (r_ref_cnt != '0)
                        r_ref_cnt <= r_ref_cnt - RW'(1);
                end
                ST_CHECK: begin
                    if (w_fire) begin
                        r_v       <= V_RESET;
                        r_ref_cnt <= RW'(REFRAC);
                    end
                end
                default: ;
            endcase
            if (r_state != ST_IDLE) begin
                if (s_if.weight_valid)
                    r_pend <= sat(w_pend_ext + w_w_ext);
                if (s_if.step) begin
                    if (r_step_pend)
                        r_step_ovf <= 1'b1;
                    else
                        r_step_pend <= 1'b1;
                end
            end
        end
    end

    assign s_if.spike_out = (r_state == ST_FIRE);
    assign s_if.spike_id  = (r_state == ST_FIRE) ? NEURON_ID : 7'd0;
    assign v_mem          = r_v;
    assign refractory     = (r_ref_cnt != '0);
    assign busy           = (r_state != ST_IDLE);
    assign step_ovf       = r_step_ovf;
endmodule
